// File: rtl/pushable_object_mover.sv
// rtl/pushable_object_mover.sv - cell-aligned push/wobble/fall/crash motion FSM for a pushable object
//
// Purpose:
//   Fixed-point position and state machine for a pushable, falling object such as a
//   gold bag or a boulder. It sits between the collision/terrain logic and the object's
//   draw block, and produces the object's pixel top-left corner plus its status.
//   All motion is evaluated on startOfFrame. The one exception is CRASHED -> EATEN,
//   which reacts on any cycle.
//
// Ports:
//   clk           in   1        system clock
//   reset         in   1        synchronous active-high reset
//   startOfFrame  in   1        one-cycle frame pulse; all motion happens on it
//   collision     in   1        push contact from the player (any cycle)
//   side          in   1        push origin: 0 = from left (move right), 1 = from right (move left)
//   push_blocked  in   1        target cell is occupied (sampled on startOfFrame)
//   can_fall      in   1        the cell below is empty (sampled on startOfFrame)
//   been_eaten    in   1        player consumed the crashed object (level)
//   respawn       in   1        return to the initial position (level, beats everything)
//   topLeftX      out  COORD_W  signed pixel X
//   topLeftY      out  COORD_W  signed pixel Y
//   obj_state     out  4        0 rest/moving, 1 falling, 2 crashed, 3 eaten
//   fsm_code      out  3        0 IDLE,1 PUSH_R,2 PUSH_L,3 WOBBLE,4 FALL,5 SETTLE,6 CRASHED,7 EATEN
//   tilt          out  2        0 upright, 1 tilt left, 2 tilt right, 3 broken sprite

module pushable_object_mover #(
  parameter int INITIAL_X     = 32,
  parameter int INITIAL_Y     = 160,
  parameter int COORD_W       = 11,
  parameter int FRAC_BITS     = 6,
  parameter int CELL_LOG2     = 5,
  parameter int X_SPEED       = 128,
  parameter int Y_SPEED       = 128,
  parameter int WOBBLE_FRAMES = 50,
  parameter int CRASH_CELLS   = 2,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 608
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic                      collision,
  input  logic                      side,
  input  logic                      push_blocked,
  input  logic                      can_fall,
  input  logic                      been_eaten,
  input  logic                      respawn,
  output logic signed [COORD_W-1:0] topLeftX,
  output logic signed [COORD_W-1:0] topLeftY,
  output logic [3:0]                obj_state,
  output logic [2:0]                fsm_code,
  output logic [1:0]                tilt
);

  // Position register width: pixel coordinate plus fraction.
  localparam int PW = COORD_W + FRAC_BITS;
  // Bits that must be zero for the position to sit exactly on a cell boundary.
  localparam int AW = CELL_LOG2 + FRAC_BITS;
  // The wobble counter is at least 6 bits wide, because the tilt pattern reads cnt[5:4].
  localparam int CW = ($clog2(WOBBLE_FRAMES) > 6) ? $clog2(WOBBLE_FRAMES) : 6;
  // The push-target range check runs two bits wider than the coordinate,
  // so that adding one cell can never wrap.
  localparam int XW = COORD_W + 2;

  localparam logic signed [PW-1:0] INIT_X_FP = PW'(INITIAL_X * (1 << FRAC_BITS));
  localparam logic signed [PW-1:0] INIT_Y_FP = PW'(INITIAL_Y * (1 << FRAC_BITS));
  localparam logic signed [PW-1:0] X_STEP    = PW'(X_SPEED);
  localparam logic signed [PW-1:0] Y_STEP    = PW'(Y_SPEED);
  localparam logic signed [XW-1:0] CELL_S    = XW'(1 << CELL_LOG2);
  localparam logic signed [XW-1:0] XMIN_S    = XW'(X_MIN);
  localparam logic signed [XW-1:0] XMAX_S    = XW'(X_MAX);
  localparam logic [CW-1:0]        WOB_LAST  = CW'(WOBBLE_FRAMES - 1);
  localparam logic [3:0]           CRASH_N   = 4'((CRASH_CELLS > 15) ? 15 : CRASH_CELLS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_R  = 3'd1,
    S_PUSH_L  = 3'd2,
    S_WOBBLE  = 3'd3,
    S_FALL    = 3'd4,
    S_SETTLE  = 3'd5,
    S_CRASHED = 3'd6,
    S_EATEN   = 3'd7
  } state_t;

  state_t                state;
  logic signed [PW-1:0]  pos_x;
  logic signed [PW-1:0]  pos_y;
  logic [CW-1:0]         cnt;
  logic [3:0]            cells;
  logic                  push_latch;
  logic                  push_side;

  // A collision arriving on the frame cycle itself still counts for that frame.
  // It also overrides the side captured earlier in the frame.
  logic push_req;
  logic push_dir;
  assign push_req = push_latch | collision;
  assign push_dir = collision ? side : push_side;

  // Pixel X of the cell the push would move into. IDLE is always cell-aligned.
  logic signed [COORD_W-1:0] x_px;
  logic signed [XW-1:0]      x_ext;
  logic signed [XW-1:0]      tgt_x;
  logic                      tgt_ok;
  assign x_px   = pos_x[PW-1:FRAC_BITS];
  assign x_ext  = {{2{x_px[COORD_W-1]}}, x_px};
  assign tgt_x  = push_dir ? (x_ext - CELL_S) : (x_ext + CELL_S);
  assign tgt_ok = (tgt_x >= XMIN_S) && (tgt_x <= XMAX_S);

  // Horizontal step. IDLE uses the direction of the new push; the push states use their own.
  logic                 step_left;
  logic signed [PW-1:0] x_step;
  logic                 x_step_aln;
  logic signed [PW-1:0] y_step;
  logic                 y_step_aln;
  logic [3:0]           cells_inc;
  assign step_left  = (state == S_IDLE) ? push_dir : (state == S_PUSH_L);
  assign x_step     = step_left ? (pos_x - X_STEP) : (pos_x + X_STEP);
  assign x_step_aln = (x_step[AW-1:0] == '0);
  assign y_step     = pos_y + Y_STEP;
  assign y_step_aln = (y_step[AW-1:0] == '0);
  assign cells_inc  = (cells == 4'd15) ? cells : (cells + 4'd1);

  always_ff @(posedge clk) begin
    if (reset || respawn) begin
      state      <= S_IDLE;
      pos_x      <= INIT_X_FP;
      pos_y      <= INIT_Y_FP;
      cnt        <= '0;
      cells      <= '0;
      push_latch <= 1'b0;
      push_side  <= 1'b0;
    end else begin
      if (startOfFrame) begin
        push_latch <= 1'b0;
      end else if (collision) begin
        push_latch <= 1'b1;
        push_side  <= side;
      end

      case (state)
        S_IDLE: begin
          if (startOfFrame) begin
            // A push wins over falling when both are possible in the same frame.
            if (push_req && !push_blocked && tgt_ok) begin
              pos_x <= x_step;
              // The first step is taken on the deciding frame. A step of one full cell
              // therefore lands back in IDLE straight away.
              state <= x_step_aln ? S_IDLE : (push_dir ? S_PUSH_L : S_PUSH_R);
            end else if (can_fall) begin
              state <= S_WOBBLE;
              cnt   <= '0;
            end
          end
        end
        S_PUSH_R, S_PUSH_L: begin
          if (startOfFrame) begin
            pos_x <= x_step;
            if (x_step_aln) state <= S_IDLE;
          end
        end
        S_WOBBLE: begin
          if (startOfFrame) begin
            if (cnt == WOB_LAST) begin
              state <= S_FALL;
              cells <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FALL: begin
          if (startOfFrame) begin
            pos_y <= y_step;
            if (y_step_aln) begin
              cells <= cells_inc;
              state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (startOfFrame) begin
            if (can_fall) begin
              state <= S_FALL;
            end else if (cells >= CRASH_N) begin
              state <= S_CRASHED;
            end else begin
              state <= S_IDLE;
              cells <= '0;
            end
          end
        end
        S_CRASHED: begin
          if (been_eaten) state <= S_EATEN;
        end
        default: begin
          // S_EATEN is terminal until respawn or reset.
        end
      endcase
    end
  end

  assign topLeftX = pos_x[PW-1:FRAC_BITS];
  assign topLeftY = pos_y[PW-1:FRAC_BITS];
  assign fsm_code = state;

  always_comb begin
    obj_state = 4'd0;
    tilt      = 2'd0;
    case (state)
      S_WOBBLE: begin
        // The sprite rocks upright, left, upright, right as the counter climbs.
        case (cnt[5:4])
          2'd1:    tilt = 2'd1;
          2'd3:    tilt = 2'd2;
          default: tilt = 2'd0;
        endcase
      end
      S_FALL, S_SETTLE: obj_state = 4'd1;
      S_CRASHED: begin
        obj_state = 4'd2;
        tilt      = 2'd3;
      end
      S_EATEN:   obj_state = 4'd3;
      default: begin
        obj_state = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pushable_object_mover.sv
// tb/tb_pushable_object_mover.sv - self-checking bench for pushable_object_mover
module tb_pushable_object_mover;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic coll = 1'b0;
  logic sd = 1'b0;
  logic pb = 1'b0;
  logic cf = 1'b0;
  logic eaten = 1'b0;
  logic resp = 1'b0;
  logic signed [10:0] top_x;
  logic signed [10:0] top_y;
  logic [3:0] obj_state;
  logic [2:0] fsm_code;
  logic [1:0] tilt;

  int errors = 0;
  int checks = 0;

  // Reference model. Positions are in 1/64 pixel; one cell is 32 px (2048 units).
  // The mode numbers follow the fsm_code values the design publishes.
  int m_x, m_y, m_mode, m_wob, m_cells;
  bit m_latch, m_side;

  always #5 clk = ~clk;

  pushable_object_mover dut (
    .clk(clk), .reset(rst), .startOfFrame(sof), .collision(coll), .side(sd),
    .push_blocked(pb), .can_fall(cf), .been_eaten(eaten), .respawn(resp),
    .topLeftX(top_x), .topLeftY(top_y), .obj_state(obj_state), .fsm_code(fsm_code), .tilt(tilt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock, using the inputs as they stand at the coming edge.
  task automatic model_clk();
    bit preq, pdir;
    int target;
    if (rst || resp) begin
      m_x = 32 * 64; m_y = 160 * 64; m_mode = 0; m_wob = 0; m_cells = 0;
      m_latch = 0; m_side = 0;
      return;
    end
    preq = m_latch || coll;
    pdir = coll ? sd : m_side;
    if (sof) m_latch = 0;
    else if (coll) begin m_latch = 1; m_side = sd; end
    if (m_mode == 6) begin
      if (eaten) m_mode = 7;
    end else if (sof) begin
      case (m_mode)
        0: begin
          target = m_x / 64 + (pdir ? -32 : 32);
          if (preq && !pb && target >= 0 && target <= 608) begin
            m_x += pdir ? -128 : 128;
            m_mode = (m_x % 2048 == 0) ? 0 : (pdir ? 2 : 1);
          end else if (cf) begin
            m_mode = 3; m_wob = 0;
          end
        end
        1: begin m_x += 128; if (m_x % 2048 == 0) m_mode = 0; end
        2: begin m_x -= 128; if (m_x % 2048 == 0) m_mode = 0; end
        3: begin
          if (m_wob == 49) begin m_mode = 4; m_cells = 0; end
          else m_wob++;
        end
        4: begin
          m_y += 128;
          if (m_y % 2048 == 0) begin
            m_cells = (m_cells < 15) ? m_cells + 1 : 15;
            m_mode = 5;
          end
        end
        5: begin
          if (cf) m_mode = 4;
          else if (m_cells >= 2) m_mode = 6;
          else begin m_mode = 0; m_cells = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    int e_obj, e_tilt, ph;
    e_obj = (m_mode == 4 || m_mode == 5) ? 1 : (m_mode == 6) ? 2 : (m_mode == 7) ? 3 : 0;
    e_tilt = 0;
    if (m_mode == 6) e_tilt = 3;
    if (m_mode == 3) begin
      ph = (m_wob / 16) % 4;
      e_tilt = (ph == 1) ? 1 : (ph == 3) ? 2 : 0;
    end
    chk("model_x", int'(top_x), m_x / 64);
    chk("model_y", int'(top_y), m_y / 64);
    chk("model_fsm", int'(fsm_code), m_mode);
    chk("model_obj", int'(obj_state), e_obj);
    chk("model_tilt", int'(tilt), e_tilt);
  endtask

  task automatic tick();
    model_clk();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // A frame is three cycles: the frame pulse followed by two quiet cycles.
  task automatic frame();
    sof = 1'b1; tick();
    sof = 1'b0; tick(); tick();
  endtask

  task automatic push(input bit s);
    coll = 1'b1; sd = s; tick();
    coll = 1'b0;
  endtask

  task automatic do_respawn();
    resp = 1'b1; tick(); resp = 1'b0;
  endtask

  initial begin
    // 1: reset, then quiet frames.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_x", int'(top_x), 32);
    chk("rst_y", int'(top_y), 160);
    chk("rst_fsm", int'(fsm_code), 0);
    chk("rst_obj", int'(obj_state), 0);
    chk("rst_tilt", int'(tilt), 0);
    for (int i = 0; i < 5; i++) begin
      frame();
      chk("idle_x", int'(top_x), 32);
      chk("idle_fsm", int'(fsm_code), 0);
    end

    // 2: push right one cell, then a blocked push, then back left and against X_MIN.
    push(0); frame();
    chk("push_r_fsm", int'(fsm_code), 1);
    repeat (15) frame();
    chk("push_r_x", int'(top_x), 64);
    chk("push_r_done", int'(fsm_code), 0);
    pb = 1'b1; push(0); frame(); pb = 1'b0;
    chk("blocked_x", int'(top_x), 64);
    chk("blocked_fsm", int'(fsm_code), 0);
    push(1); frame();
    chk("push_l_fsm", int'(fsm_code), 2);
    repeat (15) frame();
    chk("push_l_x", int'(top_x), 32);
    push(1); repeat (16) frame();
    chk("to_min_x", int'(top_x), 0);
    push(1); frame();
    chk("xmin_x", int'(top_x), 0);
    chk("xmin_fsm", int'(fsm_code), 0);

    // Walk right up to X_MAX; one more push must not move the object.
    do_respawn();
    for (int c = 0; c < 18; c++) begin
      push(0); repeat (16) frame();
    end
    chk("to_max_x", int'(top_x), 608);
    push(0); frame();
    chk("xmax_x", int'(top_x), 608);
    chk("xmax_fsm", int'(fsm_code), 0);

    // 3: wobble with its tilt pattern, then fall one cell.
    do_respawn();
    cf = 1'b1;
    for (int f = 1; f <= 50; f++) begin
      frame();
      chk("wobble_fsm", int'(fsm_code), 3);
      if (f == 17) chk("tilt_left", int'(tilt), 1);
      if (f == 33) chk("tilt_mid", int'(tilt), 0);
      if (f == 49) chk("tilt_right", int'(tilt), 2);
    end
    frame();
    chk("fall_fsm", int'(fsm_code), 4);
    chk("fall_obj", int'(obj_state), 1);
    repeat (16) frame();
    chk("fall_y", int'(top_y), 192);
    chk("settle_fsm", int'(fsm_code), 5);

    // 4: one cell fallen then floor -> IDLE. Two cells -> crash, then eaten.
    cf = 1'b0; frame();
    chk("land_fsm", int'(fsm_code), 0);
    chk("land_obj", int'(obj_state), 0);
    cf = 1'b1;
    repeat (51 + 16) frame();
    chk("fall2a_y", int'(top_y), 224);
    frame(); repeat (16) frame();
    chk("fall2b_y", int'(top_y), 256);
    cf = 1'b0; frame();
    chk("crash_fsm", int'(fsm_code), 6);
    chk("crash_obj", int'(obj_state), 2);
    chk("crash_tilt", int'(tilt), 3);
    cf = 1'b1; push(0); repeat (3) frame(); cf = 1'b0;
    chk("crash_frozen_x", int'(top_x), 32);
    chk("crash_frozen_y", int'(top_y), 256);
    eaten = 1'b1; tick(); eaten = 1'b0;
    chk("eaten_obj", int'(obj_state), 3);
    chk("eaten_tilt", int'(tilt), 0);

    // 5: push and fall in the same frame -> the push wins.
    do_respawn();
    chk("respawn_y", int'(top_y), 160);
    push(0); cf = 1'b1; frame();
    chk("push_wins", int'(fsm_code), 1);
    repeat (15) frame();
    chk("push_wins_x", int'(top_x), 64);

    // 6: respawn part-way through a fall, then reset part-way through PUSH_L.
    repeat (51 + 8) frame();
    chk("midfall_y", int'(top_y), 176);
    chk("midfall_fsm", int'(fsm_code), 4);
    do_respawn();
    chk("resp_fall_y", int'(top_y), 160);
    chk("resp_fall_fsm", int'(fsm_code), 0);
    cf = 1'b0;
    push(1); repeat (3) frame();
    chk("midpush_fsm", int'(fsm_code), 2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_push_x", int'(top_x), 32);
    chk("rst_push_obj", int'(obj_state), 0);
    chk("rst_push_fsm", int'(fsm_code), 0);

    // Random traffic. can_fall is suppressed deep down so that Y stays inside the coordinate range.
    for (int i = 0; i < 1800; i++) begin
      sof   = (i % 3 == 0);
      coll  = ($urandom_range(0, 7) == 0);
      sd    = 1'($urandom_range(0, 1));
      pb    = ($urandom_range(0, 3) == 0);
      if (sof) cf = ($urandom_range(0, 2) != 0) && (m_y < 700 * 64);
      eaten = ($urandom_range(0, 15) == 0);
      resp  = ($urandom_range(0, 299) == 0);
      tick();
    end
    sof = 1'b0; coll = 1'b0; eaten = 1'b0; resp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
